// File: rtl/rca_sum_accumulator.sv
// Block accumulator for the 4-bit RCA sum word: sums up to N_SAMPLES words and emits the total.
// Optional build macro RCA_SUM_ACC_SATURATE_EN clamps the accumulator instead of wrapping.
module rca_sum_accumulator #(
  parameter int IN_W      = 5,
  parameter int ACC_W     = 12,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {S_ACCUM = 1'b0, S_DONE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_N = CNT_W'(N_SAMPLES);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W:0]   w_carry;
  logic [ACC_W-1:0] w_acc_upd;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_close;

`ifdef RCA_SUM_ACC_SATURATE_EN
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] s, input logic c);
    return c ? {ACC_W{1'b1}} : s;
  endfunction
`endif

  // Ripple chain of full-adder cells; each stage is a drop-in point for approximate FA variants.
  assign w_addend   = ACC_W'(in_sum);
  assign w_carry[0] = 1'b0;

  for (genvar g = 0; g < ACC_W; g++) begin : g_fa
    assign w_sum[g]       = r_acc[g] ^ w_addend[g] ^ w_carry[g];
    assign w_carry[g + 1] = (r_acc[g] & w_addend[g]) | (w_carry[g] & (r_acc[g] ^ w_addend[g]));
  end

`ifdef RCA_SUM_ACC_SATURATE_EN
  assign w_acc_upd = sat_acc(w_sum, w_carry[ACC_W]);
`else
  assign w_acc_upd = w_sum;
`endif

  assign in_ready  = (r_state == S_ACCUM) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_close     = 1'b0;
    case (r_state)
      S_ACCUM: begin
        if (w_in_acc) begin
          w_acc_nxt   = w_acc_upd;
          w_count_nxt = r_count + CNT_W'(1);
          w_ovf_nxt   = r_ovf | w_carry[ACC_W];
          // Nth sample and in_last together still form a single close
          if ((w_count_nxt == LP_N) || in_last) begin
            w_close     = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (w_out_acc) begin
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_ACCUM;
        end
      end
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      // Result registers hold their last block until the next close
      if (w_close) begin
        r_out_acc   <= w_acc_nxt;
        r_out_count <= w_count_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Directed bench for rca_sum_accumulator: default build plus a narrow 6-bit/4-sample instance.
module tb_rca_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: IN_W=5, ACC_W=12, N_SAMPLES=8, CNT_W=4
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
  logic [4:0]  a_in_sum;
  logic [11:0] a_out_acc;
  logic [3:0]  a_out_count;

  // Narrow instance: ACC_W=6, N_SAMPLES=4, CNT_W=3
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [4:0]  b_in_sum;
  logic [5:0]  b_out_acc;
  logic [2:0]  b_out_count;

  rca_sum_accumulator u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  rca_sum_accumulator #(.IN_W(5), .ACC_W(6), .N_SAMPLES(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_sum = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sum = '0; b_in_last = 1'b0; b_out_ready = 1'b0;

    // Reset cycle
    tick();
    chk("rst_in_ready", 32'(a_in_ready), 0);
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_acc", 32'(a_out_acc), 0);
    chk("rst_out_count", 32'(a_out_count), 0);
    chk("rst_out_ovf", 32'(a_out_ovf), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 1);

    // Block of 1..8 back-to-back
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_sum = 5'(i);
      tick();
      if (i == 7) chk("blk1_no_valid_early", 32'(a_out_valid), 0);
    end
    a_in_valid = 1'b0;
    chk("blk1_out_valid", 32'(a_out_valid), 1);
    chk("blk1_out_acc", 32'(a_out_acc), 36);
    chk("blk1_out_count", 32'(a_out_count), 8);
    chk("blk1_out_ovf", 32'(a_out_ovf), 0);
    chk("blk1_done_in_ready", 32'(a_in_ready), 0);
    tick();
    chk("blk1_after_out_valid", 32'(a_out_valid), 0);
    chk("blk1_after_in_ready", 32'(a_in_ready), 1);
    chk("blk1_after_hold_acc", 32'(a_out_acc), 36);

    // Early close with in_last: 31+31+4
    a_in_valid = 1'b1;
    a_in_sum = 5'd31; tick();
    a_in_sum = 5'd31; tick();
    a_in_sum = 5'd4; a_in_last = 1'b1; tick();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    chk("blk2_out_valid", 32'(a_out_valid), 1);
    chk("blk2_out_acc", 32'(a_out_acc), 66);
    chk("blk2_out_count", 32'(a_out_count), 3);
    chk("blk2_out_ovf", 32'(a_out_ovf), 0);
    tick();

    // Backpressure: block 5+6 held in DONE while upstream keeps offering 9
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_sum = 5'd5; tick();
    a_in_sum = 5'd6; a_in_last = 1'b1; tick();
    a_in_sum = 5'd9;
    chk("blk3_out_acc_from_zero", 32'(a_out_acc), 11);
    chk("blk3_out_count", 32'(a_out_count), 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_out_valid", 32'(a_out_valid), 1);
      chk("stall_in_ready", 32'(a_in_ready), 0);
      chk("stall_out_acc", 32'(a_out_acc), 11);
      chk("stall_out_count", 32'(a_out_count), 2);
    end
    a_out_ready = 1'b1;
    tick();
    chk("release_out_valid", 32'(a_out_valid), 0);
    chk("release_in_ready", 32'(a_in_ready), 1);
    tick();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    chk("held_sample_valid", 32'(a_out_valid), 1);
    chk("held_sample_acc", 32'(a_out_acc), 9);
    chk("held_sample_count", 32'(a_out_count), 1);
    tick();

    // Reset mid-block after 4+5+6
    a_in_valid = 1'b1;
    a_in_sum = 5'd4; tick();
    a_in_sum = 5'd5; tick();
    a_in_sum = 5'd6; tick();
    a_in_valid = 1'b0;
    chk("mid_no_valid", 32'(a_out_valid), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_sum = 5'd2;
    for (int i = 0; i < 8; i++) tick();
    a_in_valid = 1'b0;
    chk("after_rst_out_valid", 32'(a_out_valid), 1);
    chk("after_rst_out_acc", 32'(a_out_acc), 16);
    chk("after_rst_out_count", 32'(a_out_count), 8);
    chk("after_rst_out_ovf", 32'(a_out_ovf), 0);

    // Reset while in DONE
    rst = 1'b1; tick();
    chk("done_rst_out_valid", 32'(a_out_valid), 0);
    chk("done_rst_out_acc", 32'(a_out_acc), 0);
    chk("done_rst_out_count", 32'(a_out_count), 0);
    chk("done_rst_in_ready_during", 32'(a_in_ready), 0);
    rst = 1'b0; #1;
    chk("done_rst_in_ready_after", 32'(a_in_ready), 1);

    // Narrow instance: 4 x 31 overflows 6 bits
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_sum = 5'd31;
    for (int i = 0; i < 4; i++) tick();
    b_in_valid = 1'b0;
    chk("ovf_out_valid", 32'(b_out_valid), 1);
`ifdef RCA_SUM_ACC_SATURATE_EN
    chk("ovf_out_acc", 32'(b_out_acc), 63);
`else
    chk("ovf_out_acc", 32'(b_out_acc), 60);
`endif
    chk("ovf_out_count", 32'(b_out_count), 4);
    chk("ovf_out_ovf", 32'(b_out_ovf), 1);
    tick();

    // Following block clears the sticky flag: 1+2 with last
    b_in_valid = 1'b1;
    b_in_sum = 5'd1; tick();
    b_in_sum = 5'd2; b_in_last = 1'b1; tick();
    b_in_valid = 1'b0; b_in_last = 1'b0;
    chk("ovf_next_acc", 32'(b_out_acc), 3);
    chk("ovf_next_ovf", 32'(b_out_ovf), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_sum_accumulator.md
Name: rca_sum_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit ripple-carry adder; consumes its 5-bit sum word.
- Accumulates a block of sums into a wider register and emits the block total with a sample count and overflow flag.
- Valid/ready on both sides.
- The internal accumulate adder is a ripple chain of the team's full-adder cells, so approximate full-adder variants can be substituted for ALS experiments.

Parameters:
- IN_W, 5: width of the incoming sum word (adder out[4:0]).
- ACC_W, 12: accumulator/result width; must be >= IN_W.
- N_SAMPLES, 8: samples per block; must be >= 1.
- CNT_W, $clog2(N_SAMPLES+1): width of the sample counter and out_count (derived).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream sum word valid
- in_ready  output  1  block can accept a sum this cycle
- in_sum  input  IN_W  sum word from the adder, unsigned
- in_last  input  1  qualifies in_sum; closes the block early
- out_valid  output  1  block result valid
- out_ready  input  1  downstream accepts result
- out_acc  output  ACC_W  block total, unsigned
- out_count  output  CNT_W  samples contained in the block (1..N_SAMPLES)
- out_ovf  output  1  sticky: accumulator carried out during this block

Behaviour:
- Reset: one cycle of rst=1 at a clock edge.
  - Forces state ACCUM, acc=0, count=0, ovf=0.
  - Outputs: out_valid=0, out_acc=0, out_count=0, out_ovf=0, in_ready=0 during the reset cycle, in_ready=1 from the next cycle.
  - Reset mid-block or in DONE discards all partial or pending data; rst has priority over every other event.
- Input accept: in_valid & in_ready at a rising edge.
- Output accept: out_valid & out_ready at a rising edge.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On input accept: acc <= acc + zero-extended in_sum; count <= count+1; ovf <= ovf | carry-out of the ACC_W-bit add (default build wraps modulo 2^ACC_W).
  - If accepted sample makes count==N_SAMPLES, or in_last=1: go to DONE. out_acc, out_count, out_ovf are loaded with the updated values in the same edge.
  - in_last together with the Nth sample is one close, not two.
- State DONE:
  - out_valid=1, in_ready=0; out_acc/out_count/out_ovf held stable until output accept.
  - On output accept: acc=0, count=0, ovf=0, go to ACCUM; in_ready=1 the following cycle (no same-cycle bypass).
- Latency: out_valid rises the cycle after the closing input accept.
- Throughput: max 1 sample/cycle; one bubble cycle per block (the DONE cycle).
- in_valid with in_ready=0: no state change; upstream must hold data.
- in_valid=0 in ACCUM: acc and count hold, no timeout.
- out_acc, out_count, out_ovf are registered and stay at their last value after leaving DONE until the next load; downstream qualifies them with out_valid.
- N_SAMPLES=1: every accepted sample closes a block.

Optional Feature:
- Macro: RCA_SUM_ACC_SATURATE_EN.
- Defined: on carry-out, acc is clamped to 2^ACC_W-1 and stays saturated for the rest of the block. out_ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W and out_ovf flags the wrap.
- Counter, handshake and timing are identical in both builds.

Test Plan:
- Reset then 8 sums 1..8 back-to-back, out_ready=1 -> out_valid one cycle after 8th accept; out_acc=36, out_count=8, out_ovf=0. in_ready=0 in the DONE cycle, 1 in the next.
- Sums 31,31,4 with in_last on 4 -> out_acc=66, out_count=3, out_ovf=0; next block starts from acc=0.
- ACC_W=6, N_SAMPLES=4, sums 31,31,31,31:
  - wrap build -> out_acc=124 mod 64=60, out_ovf=1.
  - RCA_SUM_ACC_SATURATE_EN build -> out_acc=63, out_ovf=1.
- Block closes, out_ready held 0 for 5 cycles with in_valid=1 -> out_valid and outputs stable, in_ready=0, no samples consumed. out_ready=1 -> next sample accepted the cycle after.
- rst asserted after 3 of 8 samples (acc=15), then 8 sums of 2 -> out_acc=16, out_count=8; pre-reset samples absent.
- rst asserted while in DONE -> out_valid=0 next cycle, outputs cleared to 0, in_ready=1 the cycle after.
